sad_job_scheduler: RTL
======================

Name: sad_job_scheduler

Overview:
Shares one SAD compute engine between N requesting clients. Picks one requester per job with round-robin fairness and holds the grant for the whole job. Sequences the engine through start, done and abort, and runs a watchdog timeout. Sits between the client request vectors and the single SAD engine in the cal_sad subsystem.

Parameters:
N, 16, number of requesting clients (2..32)
LEN_W, 8, width of the job length field (pixel-block count)
TMO_W, 12, width of the watchdog counter
TIMEOUT, 4000, cycles in BUSY before a job is aborted (must be < 2**TMO_W)

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  synchronous, active-high reset
req  input  N  per-client job request level; held until that client's done or err
req_len  input  N*LEN_W  per-client job length; client i occupies bits [i*LEN_W +: LEN_W]
grant  output  N  one-hot owner of the engine; all-zero when idle
client_done  output  N  one-cycle pulse to the owner on normal completion
client_err  output  N  one-cycle pulse to the owner on timeout abort
eng_start  output  1  one-cycle start pulse to the engine
eng_len  output  LEN_W  job length; held stable from eng_start through job end
eng_id  output  $clog2(N)  index of the owner; held with eng_len
eng_done  input  1  engine completion pulse; valid only in BUSY
eng_abort  output  1  one-cycle pulse that kills the engine job
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, rst=1 at an edge):
  - state = IDLE; grant, client_done, client_err, eng_start, eng_abort = 0.
  - eng_len = 0, eng_id = 0, watchdog = 0, busy = 0.
  - Round-robin pointer = all ones, so index 0 has the highest priority.
  - Reset mid-job drops the job silently: no eng_abort and no client_err.
- FSM states: IDLE, START, BUSY, FIN.
- IDLE:
  - If |req, pick the winner with masked round-robin: the lowest set index at or above the pointer, otherwise the lowest set index overall.
  - At the next edge, register grant, eng_id and eng_len = req_len[winner], then advance the pointer to mask the winner and all lower indices.
  - If req_len[winner] == 0, go to FIN. Otherwise go to START.
  - The pointer updates only on an accepted pick, never on idle cycles.
- START:
  - eng_start = 1 for exactly this cycle; watchdog cleared.
  - Next state is BUSY.
- BUSY:
  - The watchdog increments every cycle.
  - If eng_done, go to FIN with a normal result.
  - Otherwise, if watchdog == TIMEOUT-1, pulse eng_abort for one cycle and go to FIN with an error result.
  - If eng_done and the timeout fall in the same cycle, eng_done wins: normal result, no abort.
- FIN (one cycle):
  - Pulse client_done[id] (normal) or client_err[id] (error).
  - grant is still asserted during FIN; it clears at the following edge, on entry to IDLE.
- Latency and throughput:
  - req rise to eng_start is 2 cycles; eng_done to client_done is 1 cycle.
  - A new pick happens in the IDLE cycle after FIN, so minimum job spacing is 4 cycles plus the engine time.
- Requester rules:
  - req and req_len changes from the owner after the grant are ignored (values are latched).
  - Non-owner requests wait.
  - eng_done outside BUSY is ignored.
- grant is one-hot or zero at all times. client_done and client_err are never high together.

Decomposition:
- Shared package sad_sched_pkg:
  - state enum typedef (IDLE, START, BUSY, FIN);
  - result typedef (RES_OK, RES_TMO);
  - default constants for LEN_W and TIMEOUT.
- Sub-module rr_pick_en: N-bit masked round-robin picker.
  - Combinational one-hot output plus a pointer register that advances only when its adv input is high.
  - Kept separate because the existing free-running arbiter advances its pointer on every request cycle.

Test Plan:
- Single request: req=0x0004 with len 5; engine returns eng_done 10 cycles after start. Expect eng_start 2 cycles after req rise with eng_id=2 and eng_len=5, client_done=0x0004 one cycle after eng_done, then grant=0.
- Fairness: req=0xFFFF held, with each client dropping req after its done. Expect grants in order 0,1,2,…,15 with no client granted twice before all 16 are served.
- Pointer wrap: pointer past index 9, req=0x0201. Expect grant 0x0200 first, then 0x0001.
- Timeout: grant client 3, eng_done never returns. Expect eng_abort at BUSY cycle TIMEOUT, then client_err=0x0008 and client_done=0; a second pending requester is picked next.
- Timeout race and zero length: eng_done on the same cycle the watchdog expires gives client_done and no abort. A len=0 job gives client_done with no eng_start.
- Reset mid-BUSY: assert rst for 1 cycle. All outputs go to 0, no pulses, and the pointer returns to all ones, so req=0x8001 grants client 0.

Source files
------------

// File: rtl/sad_sched_pkg.sv
// Shared types and default constants for the SAD engine job scheduler.
package sad_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        BUSY,
        FIN
    } sched_state_e;

    typedef enum logic {
        RES_OK,
        RES_TMO
    } sched_res_e;

    localparam int SCHED_LEN_W_DEF   = 8;
    localparam int SCHED_TMO_W_DEF   = 12;
    localparam int SCHED_TIMEOUT_DEF = 4000;

endpackage

// File: rtl/sad_job_scheduler_rr_pick.sv
// Masked round-robin picker whose priority pointer moves only on an accepted pick.
module rr_pick_en #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_adv,
    output logic [N-1:0] o_gnt
);

    logic [N-1:0] r_mask;
    logic [N-1:0] w_masked;
    logic [N-1:0] w_src;

    // Lowest set bit of the masked vector, falling back to the unmasked one.
    always_comb begin
        w_masked = i_req & r_mask;
        w_src    = (|w_masked) ? w_masked : i_req;
        o_gnt    = w_src & (~w_src + N'(1));
    end

    // Mask out the winner and everything below it for the next pick.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask <= '1;
        end else if (i_adv && (|o_gnt)) begin
            r_mask <= ~(o_gnt | (o_gnt - N'(1)));
        end
    end

endmodule

// File: rtl/sad_job_scheduler.sv
// Shares one SAD engine among N clients: round-robin pick, start/done/abort
// sequencing and a BUSY watchdog.
module sad_job_scheduler
    import sad_sched_pkg::*;
#(
    parameter int N       = 16,
    parameter int LEN_W   = SCHED_LEN_W_DEF,
    parameter int TMO_W   = SCHED_TMO_W_DEF,
    parameter int TIMEOUT = SCHED_TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*LEN_W-1:0]   req_len,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         client_done,
    output logic [N-1:0]         client_err,
    output logic                 eng_start,
    output logic [LEN_W-1:0]     eng_len,
    output logic [$clog2(N)-1:0] eng_id,
    input  logic                 eng_done,
    output logic                 eng_abort,
    output logic                 busy
);

    localparam int ID_W = $clog2(N);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    sched_state_e     r_state;
    sched_state_e     w_next;
    sched_res_e       r_res;
    logic [N-1:0]     r_grant;
    logic [LEN_W-1:0] r_len;
    logic [ID_W-1:0]  r_id;
    logic [TMO_W-1:0] r_wdog;

    logic [N-1:0]     w_pick;
    logic [ID_W-1:0]  w_pick_id;
    logic [LEN_W-1:0] w_pick_len;
    logic             w_adv;
    logic             w_tmo;

    assign w_adv = (r_state == IDLE) && (|req);
    assign w_tmo = (r_wdog == TMO_LAST);

    rr_pick_en #(
        .N (N)
    ) u_pick (
        .clk   (clk),
        .rst   (rst),
        .i_req (req),
        .i_adv (w_adv),
        .o_gnt (w_pick)
    );

    always_comb begin
        w_pick_id  = '0;
        w_pick_len = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick[i]) begin
                w_pick_id  = ID_W'(i);
                w_pick_len = req_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // eng_done beats a simultaneous watchdog expiry.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_adv) w_next = (w_pick_len == '0) ? FIN : START;
            START:   w_next = BUSY;
            BUSY:    if (eng_done || w_tmo) w_next = FIN;
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant <= '0;
            r_len   <= '0;
            r_id    <= '0;
            r_wdog  <= '0;
            r_res   <= RES_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_adv) begin
                        r_grant <= w_pick;
                        r_id    <= w_pick_id;
                        r_len   <= w_pick_len;
                        r_res   <= RES_OK;
                    end
                end
                START: r_wdog <= '0;
                BUSY: begin
                    r_wdog <= r_wdog + TMO_W'(1);
                    if (!eng_done && w_tmo) r_res <= RES_TMO;
                end
                FIN:     r_grant <= '0;
                default: r_grant <= '0;
            endcase
        end
    end

    assign grant       = r_grant;
    assign eng_len     = r_len;
    assign eng_id      = r_id;
    assign busy        = (r_state != IDLE);
    assign eng_start   = (r_state == START);
    assign eng_abort   = (r_state == BUSY) && !eng_done && w_tmo;
    assign client_done = (r_state == FIN && r_res == RES_OK)  ? r_grant : '0;
    assign client_err  = (r_state == FIN && r_res == RES_TMO) ? r_grant : '0;

endmodule
